fft_reorder: RTL

FFT_REORDER -- requirements
Module: fft_reorder

---
 rtl/fft_reorder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: accepts a bit-reversed FFT frame and replays it in
// natural bin order. One bank fills while the other drains.
module fft_reorder #(
  parameter int N  = 32,
  parameter int DW = 17,
  localparam int AW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic                 valid_o,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic [AW-1:0]        index_o,
  output logic                 last_o,
  output logic                 busy_o
);

  // state  | meaning
  // S_IDLE | no bank being drained; starts reading address 0 as soon as full[rb]
  // S_READ | streaming bank rb, one entry per cycle
  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_wcnt;
  logic [AW-1:0]   r_rcnt, w_rcnt_nxt;
  logic            r_wb;
  logic            r_rb, w_rb_nxt;
  logic [1:0]      r_full, w_full_nxt;
  logic [2*DW-1:0] r_mem [0:2*N-1];
  logic [2*DW-1:0] w_rd_data;
  logic            w_wr_last;
  logic            w_rd_en;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    for (int j = 0; j < AW; j++) b[j] = a[AW-1-j];
    return b;
  endfunction

  // Bank storage carries no reset; a discarded frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (valid_i) r_mem[{r_wb, bitrev(r_wcnt)}] <= {data_in_r, data_in_i};
  end

  assign w_wr_last = valid_i && (r_wcnt == AW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_wb   <= 1'b0;
    end else if (valid_i) begin
      r_wcnt <= r_wcnt + AW'(1);
      if (w_wr_last) r_wb <= ~r_wb;
    end
  end

  // Reading starts in the same cycle IDLE sees a full bank, giving c+2 latency.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rb_nxt    = r_rb;
    w_full_nxt  = r_full;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE:  w_rd_en = r_full[r_rb];
      S_READ:  w_rd_en = 1'b1;
      default: w_rd_en = 1'b0;
    endcase
    if (w_rd_en) begin
      w_rcnt_nxt  = r_rcnt + AW'(1);
      w_state_nxt = S_READ;
      if (r_rcnt == AW'(N-1)) begin
        w_full_nxt[r_rb] = 1'b0;
        w_rb_nxt         = ~r_rb;
        w_state_nxt      = r_full[~r_rb] ? S_READ : S_IDLE;
      end
    end
    if (w_wr_last) w_full_nxt[r_wb] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      r_rb    <= 1'b0;
      r_full  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_rb    <= w_rb_nxt;
      r_full  <= w_full_nxt;
    end
  end

  assign w_rd_data = r_mem[{r_rb, r_rcnt}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      index_o    <= '0;
      last_o     <= 1'b0;
    end else if (w_rd_en) begin
      valid_o    <= 1'b1;
      data_out_r <= w_rd_data[2*DW-1:DW];
      data_out_i <= w_rd_data[DW-1:0];
      index_o    <= r_rcnt;
      last_o     <= (r_rcnt == AW'(N-1));
    end else begin
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      index_o    <= '0;
      last_o     <= 1'b0;
    end
  end

  assign busy_o = (r_wcnt != '0) || (|r_full) || (r_state == S_READ);

endmodule
